ring_phase_checker: RTL
=======================

Name: ring_phase_checker

Overview:
- Sits directly downstream of ring_counter and consumes its one-hot outputs Q0..Q3.
- Verifies that the one-hot pattern is legal and rotates in the correct order.
- Acquires lock, counts full revolutions and counts and flags faults.
- Used as an on-chip monitor and as a self-checking sink in simulation benches.

Parameters:
- LOCK_N, 4, consecutive correct steps in ACQ required to enter LOCK (range 1..15)
- CNT_W, 8, width of the revolution counter (wraps)
- ERR_W, 4, width of the error counter (saturates)
- DIR, 0, 0 = expected rotation Q0->Q1->Q2->Q3->Q0; 1 = Q0->Q3->Q2->Q1->Q0

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- Q0  input  1  ring counter bit 0
- Q1  input  1  ring counter bit 1
- Q2  input  1  ring counter bit 2
- Q3  input  1  ring counter bit 3
- clr  input  1  synchronous clear of rev_cnt, err_cnt and err_sticky
- locked  output  1  high while in LOCK
- phase  output  2  index of the last valid one-hot sample
- rev_cnt  output  CNT_W  completed revolutions while locked
- err_pulse  output  1  one-cycle pulse per detected fault
- err_sticky  output  1  set on any fault; held until clr
- err_cnt  output  ERR_W  saturating fault count

Behaviour:
- Clocking: one clock. Reset is asynchronous and active-low on n_rst; there is no synchronous reset.
- Reset: state=ACQ, prev=4'b0000, good=0. All outputs are 0: locked, phase, rev_cnt, err_pulse, err_sticky, err_cnt.
- Sampling: at each posedge the input cur={Q3,Q2,Q1,Q0} is compared with the registered prev, then prev<=cur.
- Outputs are registered, so a fault sampled at edge k produces err_pulse high during cycle k..k+1.
- Definitions:
  - valid(x) = exactly one bit set.
  - next(x) = rotate left by 1 when DIR=0, rotate right by 1 when DIR=1.
  - step_ok = valid(prev) && valid(cur) && cur==next(prev).
- phase update: phase<=index(cur) whenever valid(cur); otherwise phase holds.
- FSM states: ACQ, LOCK, FAULT.
- ACQ:
  - If step_ok: good<=good+1.
  - If not step_ok: good<=0.
  - When good+1==LOCK_N on a step_ok edge, go to LOCK.
  - No errors are reported in ACQ.
- LOCK:
  - step_ok: stay in LOCK. If cur is phase 0 (Q0 set), rev_cnt<=rev_cnt+1, wrapping modulo 2^CNT_W.
  - Not step_ok (illegal pattern, all-zero, skip, reverse step or hold): go to FAULT; err_pulse<=1; err_sticky<=1; err_cnt<=err_cnt+1, saturating at all-ones; good<=0.
- FAULT: lasts one cycle, then unconditionally goes to ACQ with good=0. The sample taken in FAULT is recorded in prev only.
- locked = (state==LOCK), registered.
- clr:
  - Zeroes rev_cnt, err_cnt and err_sticky at the edge; clr has priority over a same-edge increment or set.
  - err_pulse still fires for a same-edge fault.
  - FSM, phase and prev are unaffected by clr.
- Reset mid-operation clears everything immediately, with no clock needed. After release, the checker re-acquires from ACQ.

Optional Feature:
- Macro: RING_CHK_HOLD_EN.
- Defined: in LOCK and ACQ, valid(cur) && cur==prev is a stall. It is not an error, does not advance good, does not change rev_cnt and does not reset good.
- Undefined: a hold is treated as not step_ok. In LOCK it is a fault; in ACQ it resets good.

Test Plan:
1. Drive from a real ring_counter; release n_rst at 7 ps, then run 100 cycles (period 10 ps). Required: locked=1 after LOCK_N=4 good steps, rev_cnt increments once every 4 cycles, err_cnt=0 and err_sticky=0 throughout.
2. Forced stimulus while locked: 0001,0010,1000 (skip). Required: err_pulse high for exactly 1 cycle, err_cnt=1, err_sticky=1, locked=0; then feed 0001,0010,0100,1000,0001 and locked=1 again after 4 good steps.
3. Faults 0011 (multi-hot) then all-zero, each injected while locked, with ERR_W=2 and 5 faults in total. Required: err_cnt reads 1 and 2 after the first two faults, then saturates at 3 and holds.
4. CNT_W=3, 8 full revolutions while locked. Required: rev_cnt sequence 1..7 then 0. Assert clr on the same edge as a fault. Required: err_cnt=0, err_sticky=0, err_pulse=1.
5. Hold 0100 for 2 cycles while locked. With RING_CHK_HOLD_EN defined: no error, locked stays 1. Without it: err_pulse=1, err_cnt=1.
6. Drop n_rst mid-LOCK between clock edges. Required: all outputs 0 immediately (asynchronous); after release, re-lock within LOCK_N+1 cycles.

Source files
------------

// File: rtl/ring_phase_checker.sv
// ring_phase_checker: monitors the one-hot outputs of a 4-stage ring counter.
// Checks legality and rotation order, acquires lock, counts revolutions,
// and flags and counts faults.
// Optional build macro RING_CHK_HOLD_EN: when defined, a repeated valid sample
// (cur == prev) is treated as a stall rather than as a fault.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_ACQ   | acquiring: counting consecutive correct steps toward LOCK_N
// ST_LOCK  | locked: counting revolutions, any bad step is a fault
// ST_FAULT | one-cycle recovery after a fault, then back to ST_ACQ
module ring_phase_checker #(
    parameter int LOCK_N = 4,
    parameter int CNT_W  = 8,
    parameter int ERR_W  = 4,
    parameter int DIR    = 0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             Q0,
    input  logic             Q1,
    input  logic             Q2,
    input  logic             Q3,
    input  logic             clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] rev_cnt,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {ST_ACQ, ST_LOCK, ST_FAULT} state_t;

    localparam logic [4:0] LOCK_N_W = 5'(LOCK_N);

    state_t     state, state_nxt;
    logic [3:0] good, good_nxt;
    logic [3:0] prev;
    logic [3:0] cur;
    logic [3:0] prev_rot;
    logic       cur_valid, prev_valid;
    logic       step_ok, stall, fault;
    logic [1:0] cur_idx;

    assign cur        = {Q3, Q2, Q1, Q0};
    assign cur_valid  = (cur != 4'b0000) && ((cur & (cur - 4'd1)) == 4'b0000);
    assign prev_valid = (prev != 4'b0000) && ((prev & (prev - 4'd1)) == 4'b0000);
    assign prev_rot   = (DIR == 0) ? {prev[2:0], prev[3]} : {prev[0], prev[3:1]};
    assign step_ok    = prev_valid && cur_valid && (cur == prev_rot);

`ifdef RING_CHK_HOLD_EN
    assign stall = cur_valid && (cur == prev) && (state != ST_FAULT);
`else
    assign stall = 1'b0;
`endif

    // A fault is only reported from LOCK; ACQ silently restarts its count.
    assign fault  = (state == ST_LOCK) && !step_ok && !stall;
    assign locked = (state == ST_LOCK);

    // One-hot to index; only used when cur_valid is true.
    always_comb begin
        cur_idx = 2'd0;
        case (cur)
            4'b0010: cur_idx = 2'd1;
            4'b0100: cur_idx = 2'd2;
            4'b1000: cur_idx = 2'd3;
            default: cur_idx = 2'd0;
        endcase
    end

    // Next-state and good-step counter logic.
    always_comb begin
        state_nxt = state;
        good_nxt  = good;
        case (state)
            ST_ACQ: begin
                if (stall) begin
                    good_nxt = good;
                end else if (step_ok) begin
                    if (({1'b0, good} + 5'd1) == LOCK_N_W) begin
                        state_nxt = ST_LOCK;
                        good_nxt  = 4'd0;
                    end else begin
                        good_nxt = good + 4'd1;
                    end
                end else begin
                    good_nxt = 4'd0;
                end
            end
            ST_LOCK: begin
                if (fault) begin
                    state_nxt = ST_FAULT;
                    good_nxt  = 4'd0;
                end
            end
            ST_FAULT: begin
                state_nxt = ST_ACQ;
                good_nxt  = 4'd0;
            end
            default: begin
                state_nxt = ST_ACQ;
                good_nxt  = 4'd0;
            end
        endcase
    end

    // State, step counter and previous-sample registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_ACQ;
            good  <= 4'd0;
            prev  <= 4'b0000;
        end else begin
            state <= state_nxt;
            good  <= good_nxt;
            prev  <= cur;
        end
    end

    // Phase tracks the last valid sample; the FAULT-cycle sample is not reported.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= 2'd0;
        end else if ((state != ST_FAULT) && cur_valid) begin
            phase <= cur_idx;
        end
    end

    // Revolution counter: wraps, counts arrivals at phase 0 while locked.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rev_cnt <= '0;
        end else if (clr) begin
            rev_cnt <= '0;
        end else if ((state == ST_LOCK) && step_ok && cur[0]) begin
            rev_cnt <= rev_cnt + CNT_W'(1);
        end
    end

    // Fault reporting; clr wins over a same-edge set but the pulse still fires.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_pulse <= fault;
            if (clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end else if (fault) begin
                err_sticky <= 1'b1;
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + ERR_W'(1);
                end
            end
        end
    end

endmodule
